// File: rtl/sodor_verif_pkg.sv
// rtl/sodor_verif_pkg.sv - shared constants and types for the Sodor verification harness
package sodor_verif_pkg;

   // Canonical RISC-V NOP: addi x0, x0, 0
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   // Major opcodes used by the constrained-instruction generator
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Responder operating mode: program preload, then fetch service
   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_SERVE = 1'b1
   } resp_state_t;

endpackage

// File: rtl/sodor_resp_delay.sv
// rtl/sodor_resp_delay.sv - fixed-depth valid/data pipeline for imem responses
module sodor_resp_delay
   import sodor_verif_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        out_valid,
   output logic [31:0] out_data
);

   logic        valid_q [LATENCY];
   logic [31:0] data_q  [LATENCY];

   // Shift valid/data one stage per cycle; empty slots carry NOP so the
   // output data is never stale or unknown while valid is low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= RV_NOP;
         end
      end else begin
         valid_q[0] <= in_valid;
         data_q[0]  <= in_valid ? in_data : RV_NOP;
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[LATENCY-1];
   assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/sodor_imem_responder.sv
// rtl/sodor_imem_responder.sv - preloadable instruction memory answering Sodor fetches
module sodor_imem_responder
   import sodor_verif_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LATENCY   = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [31:0]                load_data,
   input  logic                       load_last,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [31:0]                req_addr,
   output logic                       resp_valid,
   output logic [31:0]                resp_data,
   output logic [$clog2(DEPTH):0]     loaded_count,
   output logic                       serving,
   output logic                       misaligned_err,
   output logic                       range_err,
   output logic [15:0]                fetch_count
);

   localparam int             IW      = $clog2(DEPTH);
   localparam int             CW      = IW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   resp_state_t    state_q;
   resp_state_t    state_d;
   logic [CW-1:0]  count_q;
   logic [31:0]    mem [DEPTH];
   logic           load_fire;
   logic           req_fire;
   logic           req_misaligned;
   logic           req_out_of_range;
   logic [29:0]    req_index;
   logic [31:0]    rd_data;
   logic           mis_q;
   logic           rng_q;
   logic [15:0]    fetch_q;

   // Mode register; only reset leaves SERVE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next mode and handshake readiness
   always_comb begin
      state_d    = state_q;
      load_ready = 1'b0;
      req_ready  = 1'b0;
      case (state_q)
         ST_LOAD: begin
            load_ready = (count_q != DEPTH_C);
            if (load_valid && load_ready &&
                (load_last || count_q == DEPTH_C - CW'(1))) begin
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            req_ready = 1'b1;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   assign load_fire = load_valid & load_ready;
   assign req_fire  = req_valid & req_ready;

   // Number of program words captured so far
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load_fire) begin
         count_q <= count_q + CW'(1);
      end
   end

   // Program storage; contents survive reset, the count gates every read
   always_ff @(posedge clock) begin
      if (load_fire) begin
         mem[count_q[IW-1:0]] <= load_data;
      end
   end

   // Address decode: subtraction wraps, so addresses below the base land
   // at huge indices and fall out of range naturally.
   assign req_index        = 30'((req_addr - BASE_ADDR) >> 2);
   assign req_misaligned   = (req_addr[1:0] != 2'b00);
   assign req_out_of_range = (req_index >= 30'(count_q));
   assign rd_data          = (req_misaligned || req_out_of_range) ?
                             RV_NOP : mem[req_index[IW-1:0]];

   // Sticky fault flags, set in the cycle the offending request is accepted
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mis_q <= 1'b0;
         rng_q <= 1'b0;
      end else if (req_fire) begin
         mis_q <= mis_q | req_misaligned;
         rng_q <= rng_q | req_out_of_range;
      end
   end

   sodor_resp_delay #(
      .LATENCY (LATENCY)
   ) u_delay (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (req_fire),
      .in_data   (rd_data),
      .out_valid (resp_valid),
      .out_data  (resp_data)
   );

   // Count issued responses, wrapping at 16 bits
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_q <= '0;
      end else if (resp_valid) begin
         fetch_q <= fetch_q + 16'd1;
      end
   end

   assign loaded_count   = count_q;
   assign serving        = (state_q == ST_SERVE);
   assign misaligned_err = mis_q;
   assign range_err      = rng_q;
   assign fetch_count    = fetch_q;

endmodule

// File: tb/tb_sodor_imem_responder.sv
// tb/tb_sodor_imem_responder.sv - scoreboard bench for two responder configurations
module tb_sodor_imem_responder;
   import sodor_verif_pkg::*;

   localparam int          DEPTH = 16;
   localparam int          CW    = 5;
   localparam logic [31:0] BASES [2] = '{32'h0000_0000, 32'h8000_0000};
   localparam int          LATS  [2] = '{1, 3};

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;

   logic          lr [2];
   logic          rq [2];
   logic          rv [2];
   logic [31:0]   rd [2];
   logic [CW-1:0] lc [2];
   logic          srv [2];
   logic          me [2];
   logic          re [2];
   logic [15:0]   fc [2];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   exp_t        sb [2][$];
   logic [31:0] prog [DEPTH];
   int          n_loaded = 0;
   bit          serve_m = 0;
   bit          mis_m [2];
   bit          rng_m [2];
   int          fc_m [2];

   sodor_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) dut0 (
      .clock(clock), .reset(reset),
      .load_valid(load_valid), .load_ready(lr[0]), .load_data(load_data), .load_last(load_last),
      .req_valid(req_valid), .req_ready(rq[0]), .req_addr(req_addr),
      .resp_valid(rv[0]), .resp_data(rd[0]), .loaded_count(lc[0]), .serving(srv[0]),
      .misaligned_err(me[0]), .range_err(re[0]), .fetch_count(fc[0])
   );

   sodor_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) dut1 (
      .clock(clock), .reset(reset),
      .load_valid(load_valid), .load_ready(lr[1]), .load_data(load_data), .load_last(load_last),
      .req_valid(req_valid), .req_ready(rq[1]), .req_addr(req_addr),
      .resp_valid(rv[1]), .resp_data(rd[1]), .loaded_count(lc[1]), .serving(srv[1]),
      .misaligned_err(me[1]), .range_err(re[1]), .fetch_count(fc[1])
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: word index from byte offset, NOP for any fault
   function automatic logic [31:0] model_data(input logic [31:0] addr, input logic [31:0] base,
                                              output bit mis, output bit rng);
      int unsigned idx;
      idx = (addr - base) / 4;
      mis = (addr % 4) != 0;
      rng = idx >= n_loaded;
      if (mis || rng) return RV_NOP;
      return prog[idx];
   endfunction

   // Monitor: pop and compare on every response, police idle data and lateness
   always @(negedge clock) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (rv[i] === 1'b1) begin
            if (sb[i].size() == 0) begin
               chk($sformatf("dut%0d unexpected resp_valid", i), 32'(rv[i]), 32'd0);
            end else begin
               e = sb[i].pop_front();
               chk($sformatf("dut%0d resp_data", i), rd[i], e.data);
               chk($sformatf("dut%0d resp cycle", i), 32'(cyc), 32'(e.due));
               fc_m[i]++;
            end
         end else begin
            chk($sformatf("dut%0d idle resp_data", i), rd[i], RV_NOP);
            if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
               chk($sformatf("dut%0d missing resp", i), 32'(rv[i]), 32'd1);
               void'(sb[i].pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         sb[i].delete();
         mis_m[i] = 0;
         rng_m[i] = 0;
         fc_m[i]  = 0;
      end
      n_loaded = 0;
      serve_m  = 0;
   endtask

   task automatic check_reset_values(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s dut%0d load_ready", tag, i), 32'(lr[i]), 32'd1);
         chk($sformatf("%s dut%0d req_ready", tag, i), 32'(rq[i]), 32'd0);
         chk($sformatf("%s dut%0d resp_valid", tag, i), 32'(rv[i]), 32'd0);
         chk($sformatf("%s dut%0d resp_data", tag, i), rd[i], RV_NOP);
         chk($sformatf("%s dut%0d loaded_count", tag, i), 32'(lc[i]), 32'd0);
         chk($sformatf("%s dut%0d serving", tag, i), 32'(srv[i]), 32'd0);
         chk($sformatf("%s dut%0d misaligned_err", tag, i), 32'(me[i]), 32'd0);
         chk($sformatf("%s dut%0d range_err", tag, i), 32'(re[i]), 32'd0);
         chk($sformatf("%s dut%0d fetch_count", tag, i), 32'(fc[i]), 32'd0);
      end
   endtask

   task automatic do_reset();
      load_valid = 0;
      load_last  = 0;
      req_valid  = 0;
      reset      = 0;
      clear_model();
      tick();
      check_reset_values("reset");
      tick();
      reset = 1;
      tick();
   endtask

   task automatic load_words(input logic [31:0] words[$], input bit use_last);
      for (int k = 0; k < words.size(); k++) begin
         if ($urandom_range(3) == 0) begin
            load_valid = 0;
            tick();
         end
         load_valid = 1;
         load_data  = words[k];
         load_last  = use_last && (k == words.size() - 1);
         if (n_loaded < DEPTH) begin
            prog[n_loaded] = words[k];
            n_loaded++;
         end
         tick();
      end
      load_valid = 0;
      load_last  = 0;
      serve_m    = 1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("load dut%0d serving", i), 32'(srv[i]), 32'd1);
         chk($sformatf("load dut%0d loaded_count", i), 32'(lc[i]), 32'(n_loaded));
         chk($sformatf("load dut%0d load_ready", i), 32'(lr[i]), 32'd0);
         chk($sformatf("load dut%0d req_ready", i), 32'(rq[i]), 32'd1);
      end
   endtask

   task automatic send_req(input logic [31:0] addr);
      bit m, r;
      logic [31:0] d;
      for (int i = 0; i < 2; i++) begin
         d = model_data(addr, BASES[i], m, r);
         if (serve_m) begin
            sb[i].push_back('{data: d, due: cyc + LATS[i]});
            mis_m[i] = mis_m[i] | m;
            rng_m[i] = rng_m[i] | r;
         end
      end
      req_valid = 1;
      req_addr  = addr;
      tick();
      req_valid = 0;
   endtask

   task automatic drain(input string tag);
      req_valid = 0;
      repeat (6) tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s dut%0d pending", tag, i), 32'(sb[i].size()), 32'd0);
         chk($sformatf("%s dut%0d misaligned_err", tag, i), 32'(me[i]), 32'(mis_m[i]));
         chk($sformatf("%s dut%0d range_err", tag, i), 32'(re[i]), 32'(rng_m[i]));
         chk($sformatf("%s dut%0d fetch_count", tag, i), 32'(fc[i]), 32'(fc_m[i] % 65536));
      end
   endtask

   initial begin
      logic [31:0] words[$];
      logic [31:0] a;
      int n;

      do_reset();

      // Three-word program, back-to-back fetches
      words = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
      load_words(words, 1);
      send_req(32'h0);
      send_req(32'h4);
      send_req(32'h8);
      drain("t1");
      chk("t1 dut0 fetch_count", 32'(fc[0]), 32'd3);

      // Out-of-range then a good fetch; range flag stays set
      send_req(32'hC);
      drain("t3a");
      chk("t3 dut0 range_err", 32'(re[0]), 32'd1);
      send_req(32'h0);
      drain("t3b");
      chk("t3 dut0 range_err sticky", 32'(re[0]), 32'd1);

      // Misaligned fetch on a fresh load
      do_reset();
      load_words(words, 1);
      send_req(32'h6);
      drain("t4");
      chk("t4 dut0 misaligned_err", 32'(me[0]), 32'd1);
      chk("t4 dut0 range_err", 32'(re[0]), 32'd0);

      // Addresses just below and at the high base
      send_req(32'h7FFF_FFFC);
      send_req(32'h8000_0000);
      drain("t6");
      chk("t6 dut1 range_err", 32'(re[1]), 32'd1);

      // Randomized programs and fetch streams
      for (int round = 0; round < 5; round++) begin
         do_reset();
         n = (round == 0) ? 1 : $urandom_range(1, DEPTH);
         words.delete();
         for (int k = 0; k < n; k++) words.push_back($urandom());
         load_words(words, (n < DEPTH) ? 1'b1 : 1'($urandom_range(1)));
         for (int k = 0; k < 40; k++) begin
            if ($urandom_range(3) == 0) begin
               req_valid = 0;
               tick();
            end
            if ($urandom_range(9) == 0) begin
               a = $urandom();
            end else begin
               a = BASES[$urandom_range(1)] + 32'($urandom_range(0, n + 2)) * 4;
               if ($urandom_range(6) == 0) a = a + 32'($urandom_range(1, 3));
            end
            send_req(a);
         end
         drain($sformatf("rnd%0d", round));
      end

      // Full load without last; further load words ignored
      do_reset();
      words.delete();
      for (int k = 0; k < DEPTH; k++) words.push_back($urandom());
      load_words(words, 0);
      load_valid = 1;
      load_data  = 32'hDEAD_BEEF;
      repeat (3) tick();
      load_valid = 0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("t2 dut%0d loaded_count", i), 32'(lc[i]), 32'd16);
         chk($sformatf("t2 dut%0d load_ready", i), 32'(lr[i]), 32'd0);
      end
      send_req(32'd60);
      send_req(32'h8000_003C);
      send_req(32'd64);
      drain("t2");

      // Reset while responses are in flight
      do_reset();
      words = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};
      load_words(words, 1);
      req_valid = 1;
      req_addr  = 32'h8000_0000;
      tick();
      req_valid = 0;
      reset = 0;
      clear_model();
      tick();
      check_reset_values("t5");
      repeat (3) tick();
      reset = 1;
      tick();
      req_valid = 1;
      req_addr  = 32'h0;
      tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("t5 dut%0d serving", i), 32'(srv[i]), 32'd0);
         chk($sformatf("t5 dut%0d loaded_count", i), 32'(lc[i]), 32'd0);
         chk($sformatf("t5 dut%0d req_ready", i), 32'(rq[i]), 32'd0);
      end
      repeat (5) tick();
      req_valid = 0;
      drain("t5");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
